// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: valid/ready handshake with a 2-entry skid buffer, sync flush and bubble masking.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg #(
    parameter int                    XLEN       = 32,
    parameter int                    ALU_CTRL_W = 5,
    parameter int                    REG_ADDR_W = 5,
    parameter logic [ALU_CTRL_W-1:0] NOP_CTRL   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [XLEN-1:0]       in_op_a_i,
    input  logic [XLEN-1:0]       in_op_b_i,
    input  logic [ALU_CTRL_W-1:0] in_alu_ctrl_i,
    input  logic [REG_ADDR_W-1:0] in_reg_waddr_i,
    input  logic                  in_reg_we_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [XLEN-1:0]       out_op_a_o,
    output logic [XLEN-1:0]       out_op_b_o,
    output logic [ALU_CTRL_W-1:0] out_alu_ctrl_o,
    output logic [REG_ADDR_W-1:0] out_reg_waddr_o,
    output logic                  out_reg_we_o,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           bubble_cnt_o
);

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    typedef struct packed {
        logic [XLEN-1:0]       op_a;
        logic [XLEN-1:0]       op_b;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic [REG_ADDR_W-1:0] reg_waddr;
        logic                  reg_we;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{op_a: '0, op_b: '0, alu_ctrl: NOP_CTRL, reg_waddr: '0, reg_we: 1'b0};

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   accept;
    logic   deliver;

    // Both handshake flags decode the state register only, so in_ready_o has no path from out_ready_i.
    assign in_ready_o  = (state != SKID);
    assign out_valid_o = (state != EMPTY);
    assign accept      = in_valid_i & in_ready_o;
    assign deliver     = out_valid_o & out_ready_i;

    assign in_entry = '{op_a: in_op_a_i, op_b: in_op_b_i, alu_ctrl: in_alu_ctrl_i,
                        reg_waddr: in_reg_waddr_i, reg_we: in_reg_we_i};

    // NOTE: state and data use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= RESET_ENTRY;
            skid_q <= RESET_ENTRY;
        end else if (flush_i) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_entry;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (deliver && accept) begin
                        main_q <= in_entry;
                    end else if (deliver) begin
                        state <= EMPTY;
                    end else if (accept) begin
                        skid_q <= in_entry;
                        state  <= SKID;
                    end
                end
                SKID: begin
                    if (deliver) begin
                        main_q <= skid_q;
                        state  <= FULL;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Empty slots present a NOP; operands keep their last value since EX ignores them.
    assign out_op_a_o      = main_q.op_a;
    assign out_op_b_o      = main_q.op_b;
    assign out_alu_ctrl_o  = out_valid_o ? main_q.alu_ctrl  : NOP_CTRL;
    assign out_reg_waddr_o = out_valid_o ? main_q.reg_waddr : '0;
    assign out_reg_we_o    = out_valid_o & main_q.reg_we;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Saturating counters; flush deliberately does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!out_valid_o && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: stimulus pushes expected instructions, a negedge monitor pops on delivery.
module tb_id_ex_pipe_reg;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_op_a_i;
    logic [31:0] in_op_b_i;
    logic [4:0]  in_alu_ctrl_i;
    logic [4:0]  in_reg_waddr_i;
    logic        in_reg_we_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_op_a_o;
    logic [31:0] out_op_b_o;
    logic [4:0]  out_alu_ctrl_o;
    logic [4:0]  out_reg_waddr_o;
    logic        out_reg_we_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] bubble_cnt_o;

    typedef struct {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  alu_ctrl;
        logic [4:0]  reg_waddr;
        logic        reg_we;
    } txn_t;

    txn_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    id_ex_pipe_reg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_op_a_i      (in_op_a_i),
        .in_op_b_i      (in_op_b_i),
        .in_alu_ctrl_i  (in_alu_ctrl_i),
        .in_reg_waddr_i (in_reg_waddr_i),
        .in_reg_we_i    (in_reg_we_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_op_a_o     (out_op_a_o),
        .out_op_b_o     (out_op_b_o),
        .out_alu_ctrl_o (out_alu_ctrl_o),
        .out_reg_waddr_o(out_reg_waddr_o),
        .out_reg_we_o   (out_reg_we_o),
        .stall_cnt_o    (stall_cnt_o),
        .bubble_cnt_o   (bubble_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] a);
        txn_t t;
        t.op_a      = a;
        t.op_b      = ~a;
        t.alu_ctrl  = a[4:0];
        t.reg_waddr = a[4:0] + 5'd1;
        t.reg_we    = a[0];
        return t;
    endfunction

    task automatic drive(input logic v, input logic [31:0] a);
        txn_t t;
        t = mk(a);
        in_valid_i     = v;
        in_op_a_i      = t.op_a;
        in_op_b_i      = t.op_b;
        in_alu_ctrl_i  = t.alu_ctrl;
        in_reg_waddr_i = t.reg_waddr;
        in_reg_we_i    = t.reg_we;
    endtask

    // Offer an instruction the bench knows will be accepted, and record it as expected.
    task automatic send(input logic [31:0] a);
        drive(1'b1, a);
        q.push_back(mk(a));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid_o && out_ready_i) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_deliver: actual op_a=%h, required no delivery", out_op_a_o);
            end else begin
                txn_t e;
                e = q.pop_front();
                check("deliver_op_a", out_op_a_o, e.op_a);
                check("deliver_op_b", out_op_b_o, e.op_b);
                check("deliver_alu", {27'd0, out_alu_ctrl_o}, {27'd0, e.alu_ctrl});
                check("deliver_waddr", {27'd0, out_reg_waddr_o}, {27'd0, e.reg_waddr});
                check("deliver_we", {31'd0, out_reg_we_o}, {31'd0, e.reg_we});
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        flush_i        = 1'b0;
        out_ready_i    = 1'b0;
        in_valid_i     = 1'b0;
        in_op_a_i      = '0;
        in_op_b_i      = '0;
        in_alu_ctrl_i  = 5'h7;
        in_reg_waddr_i = 5'h3;
        in_reg_we_i    = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("rst_alu_nop", {27'd0, out_alu_ctrl_o}, 32'd0);
        check("rst_we", {31'd0, out_reg_we_o}, 32'd0);
        check("rst_op_a", out_op_a_o, 32'd0);
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
        check("rst_bubble_cnt", bubble_cnt_o, 32'd0);
        #1 rst_n = 1'b1;
        drive(1'b0, 32'd0);

        // Counters: two idle edges, one accept, then three stalled edges.
        step();
        send(32'hA1);
        step();
        drive(1'b0, 32'd0);
        step(); step(); step();
        check("stall_hold_op_a", out_op_a_o, 32'hA1);
`ifdef ID_EX_PERF_CNT_EN
        check("stall_cnt", stall_cnt_o, 32'd3);
        check("bubble_cnt", bubble_cnt_o, 32'd2);
`else
        check("stall_cnt_off", stall_cnt_o, 32'd0);
        check("bubble_cnt_off", bubble_cnt_o, 32'd0);
`endif
        out_ready_i = 1'b1;
        step();

        // Streaming four back-to-back instructions.
        for (int i = 1; i <= 4; i++) begin
            send(i);
            step();
            check("stream_out_valid", {31'd0, out_valid_o}, 32'd1);
            check("stream_in_ready", {31'd0, in_ready_o}, 32'd1);
            check("stream_op_a", out_op_a_o, i);
        end
        drive(1'b0, 32'd0);
        step();
        check("stream_drained", {31'd0, out_valid_o}, 32'd0);

        // Back-pressure into the skid entry; an offer while full must be refused.
        out_ready_i = 1'b0;
        send(32'h11);
        step();
        check("bp_in_ready_full", {31'd0, in_ready_o}, 32'd1);
        send(32'h22);
        step();
        check("bp_in_ready_skid", {31'd0, in_ready_o}, 32'd0);
        check("bp_hold_op_a", out_op_a_o, 32'h11);
        drive(1'b1, 32'h33);
        step();
        check("bp_still_skid", {31'd0, in_ready_o}, 32'd0);
        check("bp_still_op_a", out_op_a_o, 32'h11);
        drive(1'b0, 32'd0);
        out_ready_i = 1'b1;
        step();
        check("bp_second_op_a", out_op_a_o, 32'h22);
        check("bp_in_ready_back", {31'd0, in_ready_o}, 32'd1);
        step();
        check("bp_drained", {31'd0, out_valid_o}, 32'd0);

        // Bubble masking with live-looking control on the input.
        in_valid_i = 1'b0; in_alu_ctrl_i = 5'h7; in_reg_we_i = 1'b1; in_reg_waddr_i = 5'h9;
        step();
        check("bubble_valid", {31'd0, out_valid_o}, 32'd0);
        check("bubble_alu", {27'd0, out_alu_ctrl_o}, 32'd0);
        check("bubble_we", {31'd0, out_reg_we_o}, 32'd0);
        check("bubble_waddr", {27'd0, out_reg_waddr_o}, 32'd0);

        // Flush while in SKID with an input offered.
        out_ready_i = 1'b0;
        send(32'h44);
        step();
        send(32'h55);
        step();
        flush_i = 1'b1;
        drive(1'b1, 32'h66);
        step();
        flush_i = 1'b0;
        drive(1'b0, 32'd0);
        q.delete();
        check("flush_skid_valid", {31'd0, out_valid_o}, 32'd0);
        check("flush_skid_ready", {31'd0, in_ready_o}, 32'd1);
        out_ready_i = 1'b1;
        step(); step();

        // Flush while FULL: the input offered that cycle is accepted but discarded.
        out_ready_i = 1'b0;
        send(32'h77);
        step();
        flush_i = 1'b1;
        drive(1'b1, 32'h88);
        step();
        flush_i = 1'b0;
        drive(1'b0, 32'd0);
        q.delete();
        check("flush_full_valid", {31'd0, out_valid_o}, 32'd0);
        out_ready_i = 1'b1;
        step(); step();

        // Asynchronous reset away from the clock edge, then a fresh instruction.
        out_ready_i = 1'b0;
        send(32'h99);
        step();
        drive(1'b0, 32'd0);
        check("pre_rst_valid", {31'd0, out_valid_o}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        q.delete();
        check("async_rst_valid", {31'd0, out_valid_o}, 32'd0);
        check("async_rst_ready", {31'd0, in_ready_o}, 32'd1);
        check("async_rst_op_a", out_op_a_o, 32'd0);
        check("async_rst_alu", {27'd0, out_alu_ctrl_o}, 32'd0);
        #2 rst_n = 1'b1;
        out_ready_i = 1'b1;
        send(32'hC3);
        step();
        check("post_rst_valid", {31'd0, out_valid_o}, 32'd1);
        check("post_rst_op_a", out_op_a_o, 32'hC3);
        drive(1'b0, 32'd0);
        step(); step();

        check("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline stage with a valid/ready handshake on both sides, a 2-entry skid buffer, synchronous flush, and bubble masking. It sits between decode/CU and EX. It gives full throughput under EX back-pressure, and the input ready has no combinational path from out_ready_i. Invalid or flushed slots always present as a NOP to EX.

Parameters:
XLEN, 32, width of operands op_a/op_b
ALU_CTRL_W, 5, width of ALU control field
REG_ADDR_W, 5, width of destination register address
NOP_CTRL, 0, ALU control value presented when no valid instruction is held (equals NO_OP encoding)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous flush (branch mispredict/trap), highest priority
in_valid_i  in  1  ID holds a valid instruction
in_ready_o  out  1  stage can accept; registered, depends only on state
in_op_a_i  in  XLEN  operand A
in_op_b_i  in  XLEN  operand B
in_alu_ctrl_i  in  ALU_CTRL_W  ALU control from CU
in_reg_waddr_i  in  REG_ADDR_W  destination register
in_reg_we_i  in  1  register write enable
out_valid_o  out  1  EX-side instruction valid
out_ready_i  in  1  EX can consume
out_op_a_o  out  XLEN  operand A to EX
out_op_b_o  out  XLEN  operand B to EX
out_alu_ctrl_o  out  ALU_CTRL_W  ALU control to EX
out_reg_waddr_o  out  REG_ADDR_W  destination register to EX
out_reg_we_o  out  1  write enable to EX
stall_cnt_o  out  32  cycles with out_valid_o=1 and out_ready_i=0 (optional feature)
bubble_cnt_o  out  32  cycles with out_valid_o=0 (optional feature)

Behaviour:
- Storage: main entry (drives outputs) plus skid entry. FSM states: EMPTY, FULL (main valid), SKID (main and skid valid).
- Accept = in_valid_i & in_ready_o. Deliver = out_valid_o & out_ready_i.
- in_ready_o = 1 in EMPTY/FULL, 0 in SKID. out_valid_o = 1 in FULL/SKID.
- EMPTY: accept -> FULL, main <= input.
- FULL: deliver & accept -> FULL, main <= input. deliver & !accept -> EMPTY. !deliver & accept -> SKID, skid <= input. Otherwise hold.
- SKID: deliver -> FULL, main <= skid. Otherwise hold. No accept is possible.
- Latency: 1 cycle from accept to out_valid_o when EMPTY, or when FULL with deliver. Throughput 1 instr/cycle sustained.
- Ordering is strictly FIFO; no instruction is dropped or duplicated except by flush.
- Bubble masking: whenever out_valid_o=0, out_alu_ctrl_o=NOP_CTRL, out_reg_we_o=0 and out_reg_waddr_o=0. Operands hold their last value (don't-care).
- Flush: next state EMPTY regardless of current state or handshakes. Main and skid entries are invalidated. An input offered in the flush cycle counts as accepted if in_ready_o=1, but is discarded. in_ready_o=1 the cycle after flush.
- Reset: state EMPTY. All data 0, out_alu_ctrl_o=NOP_CTRL, out_reg_we_o=0, out_valid_o=0, in_ready_o=1, counters 0. Reset mid-operation discards all held entries immediately (asynchronous).

Optional Feature:
ID_EX_PERF_CNT_EN.
- Defined: stall_cnt_o and bubble_cnt_o are 32-bit counters, incremented per the port definitions. They saturate at 32'hFFFF_FFFF, are cleared only by reset, and are unaffected by flush.
- Undefined: both ports are tied to 0 and no counter logic is instantiated.

Test Plan:
- Streaming: in_valid_i=1 for 4 cycles, op_a=1..4, out_ready_i=1 -> out_valid_o from cycle 1, op_a 1,2,3,4 on consecutive cycles, in_ready_o stays 1.
- Back-pressure: send A=0x11, B=0x22 with out_ready_i=0 -> state SKID, in_ready_o=0, out_op_a_o=0x11 held. Then out_ready_i=1 -> 0x11, then 0x22 delivered, in_ready_o=1 one cycle after the first deliver.
- Bubble: in_valid_i=0 with in_alu_ctrl_i=5'h7, in_reg_we_i=1 -> out_valid_o=0, out_alu_ctrl_o=NOP_CTRL, out_reg_we_o=0.
- Flush in SKID with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, neither held entry is ever delivered.
- Async reset asserted mid-stream (not clock-aligned) -> outputs go to reset values immediately. After release, the first accepted instr appears 1 cycle later.
- With ID_EX_PERF_CNT_EN: 3 cycles stalled plus 2 idle cycles -> stall_cnt_o=3, bubble_cnt_o=2 (counted from reset). Without the macro -> both 0.
